alu_seq_unit: RTL and testbench
===============================

# alu_seq_unit

Handshaked, multi-cycle ALU responder for the lab datapath. It accepts one operation per request on a valid/ready channel, executes it, and holds the result on a valid/ready response channel until the result is taken. Single-cycle ops complete in one cycle. Shifts are computed iteratively, one bit per cycle, so the block serves as the sequential counterpart to the combinational `alu_FPGA` stimulus flow.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `SHW`, 5, shift-amount width (2^SHW ≥ WIDTH)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `a`  in  WIDTH  operand A (signed)
- `b`  in  WIDTH  operand B (signed)
- `shamt`  in  SHW  shift amount, applied to A
- `funct`  in  4  opcode
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `resp_valid`  out  1  result valid
- `resp_ready`  in  1  consumer takes result
- `out`  out  WIDTH  signed result
- `zero`, `ovf`  out  1  flags; present only with `ALU_SEQ_FLAGS_EN`

One clock; reset is asynchronous and active-low.

## Operation
- Opcodes:
  - 0 ADD: a+b
  - 1 SUB: a−b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: ~a
  - 6 SLA: a<<shamt, zero fill
  - 7 SRA: a>>>shamt, sign fill
  - 8 SRL: a>>shamt, zero fill
  - 9–15: result 0
- All arithmetic is WIDTH bits, two's complement, and wraps with no saturation.
- On handshake (`req_valid && req_ready`), `a`, `b`, `shamt` and `funct` are registered. Later input changes are ignored until the next accept.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: `req_ready`=1. On accept:
    - shift opcode with shamt≠0 → SHIFT, load counter = shamt, load working reg = a.
    - otherwise → DONE with the result computed.
  - SHIFT: each cycle shift the working reg by one bit (SLA left; SRA replicate MSB; SRL insert 0) and decrement the counter. When the counter reaches 1, the final shift lands and the state moves to DONE.
  - DONE: `resp_valid`=1, `out` stable. On `resp_ready`=1 → IDLE.
- `req_ready` is 0 in SHIFT and DONE. There is no request/response overlap.
- shamt ≥ WIDTH (when SHW allows): shift completes normally and yields 0 (SLA/SRL) or all-sign (SRA).

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `out`=0, counter 0; `zero`=0, `ovf`=0 when present.
- Latency from accept edge to `resp_valid` high:
  - 1 cycle for non-shift ops and for shamt=0.
  - shamt+1 cycles for shifts.
- Result is held indefinitely under backpressure (`resp_ready`=0). `out` must not change while `resp_valid`=1.
- `resp_valid` drops on the edge after the response handshake. A new request is accepted no earlier than the following edge. Minimum request-to-request spacing is 2 cycles for single-cycle ops.
- `req_valid` asserted in SHIFT/DONE is ignored, not queued.
- `rst_n` low at any time, including mid-shift or in DONE, immediately forces the reset values. Any in-flight result is discarded.
- `out` is registered; there are no combinational paths from inputs to `out` or `resp_valid`.

## Configuration
`ALU_SEQ_FLAGS_EN` is the only compile-time option.
- Defined:
  - `zero` and `ovf` ports exist, registered and updated together with `out`.
  - `zero` = (result == 0).
  - `ovf` = signed overflow, for ADD/SUB only: operands of equal sign (ADD) or opposite sign (SUB) produce a result of different sign. `ovf` is 0 for all other ops.
  - Both flags are held while in DONE.
- Undefined: the ports and their logic are absent. Result and timing behaviour are identical to the defined build.

## Test plan
- Reset, then a=12, b=3, funct=0, one-cycle `req_valid` → `resp_valid` on the next edge with out=15. Repeat with funct=1 → out=9, funct=2 → 0, funct=3 → 15, funct=4 → 15, funct=5 → −13.
- a=−16, funct=7, shamt=2 → `resp_valid` 3 cycles after accept, out=−4. Same with funct=8 → out=32'h3FFFFFFC. funct=6, shamt=0 → 1 cycle, out=−16.
- a=32'h80000000, funct=8, shamt=31 → `req_ready`=0 for the whole shift, out=1 after 32 cycles. Changing `a` during the shift has no effect.
- Backpressure: `resp_ready`=0 for 10 cycles after ADD completes → out and `resp_valid` stable and `req_ready`=0. `resp_ready` pulse → `resp_valid`=0 next edge, `req_ready`=1.
- Pull `rst_n` low for half a cycle mid-SHIFT (a=1, funct=6, shamt=20, cycle 5) → `resp_valid`=0 and out=0 immediately. The next request (ADD 2+2) returns 4 normally.
- With `ALU_SEQ_FLAGS_EN`:
  - ADD 32'h7FFFFFFF+1 → out=32'h80000000, ovf=1, zero=0.
  - SUB 5−5 → out=0, zero=1, ovf=0.
  - AND → ovf=0.

Source files
------------

// File: rtl/alu_seq_unit.sv
// Handshaked ALU with single-cycle logic/arith ops and bit-serial shifts.
// Optional zero/ovf flag outputs are built when ALU_SEQ_FLAGS_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | req_ready high, waiting for a request
// S_SHIFT | shifting work_q one bit per cycle, cnt_q bits still to go
// S_DONE  | resp_valid high, out held until resp_ready
module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    input  logic [3:0]       funct,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] out
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] imm_res;
    logic [WIDTH-1:0] shift_one;
    logic             is_shift_req;
`ifdef ALU_SEQ_FLAGS_EN
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             imm_ovf;
`endif

    assign is_shift_req = (funct == 4'd6) || (funct == 4'd7) || (funct == 4'd8);

    // Shift opcodes only reach this path with shamt == 0, so they pass A through.
    always_comb begin
        imm_res = '0;
        case (funct)
            4'd0:    imm_res = a + b;
            4'd1:    imm_res = a - b;
            4'd2:    imm_res = a & b;
            4'd3:    imm_res = a | b;
            4'd4:    imm_res = a ^ b;
            4'd5:    imm_res = ~a;
            4'd6,
            4'd7,
            4'd8:    imm_res = a;
            default: imm_res = '0;
        endcase
    end

`ifdef ALU_SEQ_FLAGS_EN
    always_comb begin
        imm_ovf = 1'b0;
        case (funct)
            4'd0:    imm_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (imm_res[WIDTH-1] != a[WIDTH-1]);
            4'd1:    imm_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (imm_res[WIDTH-1] != a[WIDTH-1]);
            default: imm_ovf = 1'b0;
        endcase
    end
`endif

    always_comb begin
        shift_one = '0;
        case (op_q)
            4'd6:    shift_one = {work_q[WIDTH-2:0], 1'b0};
            4'd7:    shift_one = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shift_one = {1'b0, work_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
`ifdef ALU_SEQ_FLAGS_EN
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d = funct;
                    if (is_shift_req && (shamt != '0)) begin
                        state_d = S_SHIFT;
                        cnt_d   = shamt;
                        work_d  = a;
                    end else begin
                        state_d = S_DONE;
                        out_d   = imm_res;
`ifdef ALU_SEQ_FLAGS_EN
                        zero_d  = (imm_res == '0);
                        ovf_d   = imm_ovf;
`endif
                    end
                end
            end
            S_SHIFT: begin
                work_d = shift_one;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = S_DONE;
                    out_d   = shift_one;
`ifdef ALU_SEQ_FLAGS_EN
                    zero_d  = (shift_one == '0);
                    ovf_d   = 1'b0;
`endif
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
`ifdef ALU_SEQ_FLAGS_EN
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign out        = out_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign zero = zero_q;
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed vector table, hand-written
// reset/backpressure sequences, and randomized ops against a reference model.
module tb_alu_seq_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic [3:0]  funct;
    logic        req_valid, req_ready, resp_valid, resp_ready;
    logic [31:0] out;
`ifdef ALU_SEQ_FLAGS_EN
    logic        zero, ovf;
`endif

    int total = 0;
    int passed = 0;

    alu_seq_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .funct     (funct),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .out       (out)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  f;
        logic [31:0] av;
        logic [31:0] bv;
        logic [4:0]  sh;
        logic [31:0] exp_out;
        int          exp_lat;
        logic        exp_z;
        logic        exp_o;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] f, input logic [31:0] av,
                                               input logic [31:0] bv, input logic [4:0] sh);
        logic [31:0] r;
        case (f)
            4'd0: r = av + bv;
            4'd1: r = av - bv;
            4'd2: r = av & bv;
            4'd3: r = av | bv;
            4'd4: r = av ^ bv;
            4'd5: r = ~av;
            4'd6: r = av << sh;
            4'd7: r = $signed(av) >>> sh;
            4'd8: r = av >> sh;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic ref_ovf(input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb, s;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (f == 4'd0) s = sa + sb;
        else if (f == 4'd1) s = sa - sb;
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic int ref_lat(input logic [3:0] f, input logic [4:0] sh);
        if ((f == 4'd6 || f == 4'd7 || f == 4'd8) && sh != 5'd0) return int'(sh) + 1;
        return 1;
    endfunction

    // Issue one op, scribble over the inputs while it runs, hold the response
    // for bp cycles, then take it.
    task automatic do_op(input string name, input logic [3:0] f, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] sh, input int bp,
                         input logic [31:0] exp_out, input int exp_lat,
                         input logic exp_z, input logic exp_o);
        int lat;
        int rr_bad;
        int hold_bad;
        logic [31:0] held;
        check({name, ".req_ready_idle"}, {31'd0, req_ready}, 32'd1);
        a = av; b = bv; shamt = sh; funct = f; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        rr_bad = 0;
        while (!resp_valid && lat < 200) begin
            if (req_ready) rr_bad++;
            a = $urandom; b = $urandom; shamt = 5'($urandom); funct = 4'($urandom);
            req_valid = 1'($urandom);
            tick();
            lat++;
        end
        check({name, ".latency"}, 32'(lat), 32'(exp_lat));
        check({name, ".out"}, out, exp_out);
        if (exp_lat > 1) check({name, ".req_ready_busy"}, 32'(rr_bad), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        check({name, ".zero"}, {31'd0, zero}, {31'd0, exp_z});
        check({name, ".ovf"}, {31'd0, ovf}, {31'd0, exp_o});
`endif
        held = out;
        hold_bad = 0;
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'($urandom);
            a = $urandom;
            tick();
            if (!resp_valid || req_ready || out !== held) hold_bad++;
        end
        req_valid = 1'b0;
        if (bp > 0) check({name, ".hold"}, 32'(hold_bad), 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({name, ".resp_drop"}, {31'd0, resp_valid}, 32'd0);
        check({name, ".req_ready_back"}, {31'd0, req_ready}, 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        logic [3:0]  rf;
        logic [31:0] ra, rb, rexp;
        logic [4:0]  rsh;

        vecs.push_back('{4'd0, 32'd12, 32'd3, 5'd0, 32'd15, 1, 1'b0, 1'b0});
        vecs.push_back('{4'd1, 32'd12, 32'd3, 5'd0, 32'd9, 1, 1'b0, 1'b0});
        vecs.push_back('{4'd2, 32'd12, 32'd3, 5'd0, 32'd0, 1, 1'b1, 1'b0});
        vecs.push_back('{4'd3, 32'd12, 32'd3, 5'd0, 32'd15, 1, 1'b0, 1'b0});
        vecs.push_back('{4'd4, 32'd12, 32'd3, 5'd0, 32'd15, 1, 1'b0, 1'b0});
        vecs.push_back('{4'd5, 32'd12, 32'd3, 5'd0, 32'hFFFFFFF3, 1, 1'b0, 1'b0});
        vecs.push_back('{4'd7, 32'hFFFFFFF0, 32'd0, 5'd2, 32'hFFFFFFFC, 3, 1'b0, 1'b0});
        vecs.push_back('{4'd8, 32'hFFFFFFF0, 32'd0, 5'd2, 32'h3FFFFFFC, 3, 1'b0, 1'b0});
        vecs.push_back('{4'd6, 32'hFFFFFFF0, 32'd0, 5'd0, 32'hFFFFFFF0, 1, 1'b0, 1'b0});
        vecs.push_back('{4'd8, 32'h80000000, 32'd0, 5'd31, 32'd1, 32, 1'b0, 1'b0});
        vecs.push_back('{4'd7, 32'h80000000, 32'd0, 5'd31, 32'hFFFFFFFF, 32, 1'b0, 1'b0});
        vecs.push_back('{4'd6, 32'd3, 32'd0, 5'd31, 32'h80000000, 32, 1'b0, 1'b0});
        vecs.push_back('{4'd12, 32'd5, 32'd5, 5'd3, 32'd0, 1, 1'b1, 1'b0});
        vecs.push_back('{4'd0, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 1, 1'b0, 1'b1});
        vecs.push_back('{4'd1, 32'd5, 32'd5, 5'd0, 32'd0, 1, 1'b1, 1'b0});
        vecs.push_back('{4'd1, 32'h80000000, 32'd1, 5'd0, 32'h7FFFFFFF, 1, 1'b0, 1'b1});
        vecs.push_back('{4'd2, 32'hF0F0F0F0, 32'hFFFF0000, 5'd0, 32'hF0F00000, 1, 1'b0, 1'b0});

        rst_n = 1'b0;
        a = '0; b = '0; shamt = '0; funct = '0;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        #2;
        check("reset.req_ready", {31'd0, req_ready}, 32'd1);
        check("reset.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset.out", out, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        check("reset.zero", {31'd0, zero}, 32'd0);
        check("reset.ovf", {31'd0, ovf}, 32'd0);
`endif
        #10;
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].av, vecs[i].bv, vecs[i].sh,
                  (i == 0) ? 10 : 0, vecs[i].exp_out, vecs[i].exp_lat,
                  vecs[i].exp_z, vecs[i].exp_o);
        end

        // Reset pulse in the middle of a long shift discards the in-flight op.
        do_op("pre_rst", 4'd0, 32'd7, 32'd1, 5'd0, 0, 32'd8, 1, 1'b0, 1'b0);
        a = 32'd1; b = 32'd0; shamt = 5'd20; funct = 4'd6; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_shift.req_ready", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_mid.out", out, 32'd0);
        check("rst_mid.req_ready", {31'd0, req_ready}, 32'd1);
        #3;
        rst_n = 1'b1;
        tick();
        do_op("post_rst_add", 4'd0, 32'd2, 32'd2, 5'd0, 0, 32'd4, 1, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rf  = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = (n % 4 == 0) ? ra : $urandom;
            rsh = 5'($urandom);
            rexp = ref_result(rf, ra, rb, rsh);
            do_op($sformatf("rnd%0d", n), rf, ra, rb, rsh, $urandom_range(0, 3),
                  rexp, ref_lat(rf, rsh), (rexp == 32'd0), ref_ovf(rf, ra, rb));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
